divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_pkg.sv | 22 ++
 rtl/div_ctrl_fsm.sv | 66 ++++++
 rtl/divider_seq.sv | 97 +++++++++
 tb/tb_divider_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared types and sizing for the sequential divider
package divider_pkg;

  // Default operand width of the divider.
  localparam int DIV_WIDTH = 32;

  // Iteration counter width for a given operand width (never below one bit).
  function automatic int div_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Counter width at the default operand width.
  localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

  // Controller states: waiting, iterating one bit per clock, result held.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_ctrl_fsm.sv
// rtl/div_ctrl_fsm.sv - divider sequencing: state, step counter and strobes
module div_ctrl_fsm
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic Reset,
  input  logic run_i,
  input  logic zero_i,
  output logic busy_o,
  output logic ready_o,
  output logic accept_o,
  output logic step_o
);

  localparam int CNT_W = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers, cleared immediately by Reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and strobes; Run is only honoured when no operation is in flight.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_o   = 1'b0;
    ready_o  = 1'b0;
    accept_o = 1'b0;
    step_o   = 1'b0;
    unique case (state_q)
      DIV_IDLE, DIV_DONE: begin
        ready_o = (state_q == DIV_DONE);
        if (run_i) begin
          accept_o = 1'b1;
          cnt_d    = '0;
          // A zero divisor has a fixed answer, so skip the iterations.
          state_d  = zero_i ? DIV_DONE : DIV_ITER;
        end
      end
      DIV_ITER: begin
        busy_o = 1'b1;
        step_o = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - restoring unsigned divider, one quotient bit per clock
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Ready,
  output logic             DivZero
);

  logic accept, step, div_zero;

  // The quotient register doubles as the dividend shift register: its MSB
  // feeds the partial remainder and quotient bits enter at the LSB.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_sub;
  logic             rem_ge;

  assign div_zero = (Divisor == '0);

  div_ctrl_fsm #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk      (clk),
    .Reset    (Reset),
    .run_i    (Run),
    .zero_i   (div_zero),
    .busy_o   (Busy),
    .ready_o  (Ready),
    .accept_o (accept),
    .step_o   (step)
  );

  // One restoring step at WIDTH+1 bits. The stored remainder is always below
  // the divisor, so the shifted value is below twice the divisor and the
  // difference fits a signed WIDTH+1 result: its MSB is the borrow.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dsr_q};
    rem_ge    = ~rem_sub[WIDTH];
  end

  // Datapath next state: load on accept, shift/subtract on each step, else hold.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    dz_d  = dz_q;
    if (accept) begin
      dsr_d = Divisor;
      dz_d  = div_zero;
      if (div_zero) begin
        quo_d = '1;
        rem_d = Dividend;
      end else begin
        quo_d = Dividend;
        rem_d = '0;
      end
    end else if (step) begin
      quo_d = {quo_q[WIDTH-2:0], rem_ge};
      rem_d = rem_ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    end
  end

  // Datapath registers, cleared immediately by Reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      dz_q  <= dz_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivZero   = dz_q & Ready;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - scoreboard bench for divider_seq
module tb_divider_seq;
  import divider_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic [W-1:0] Dividend;
  logic [W-1:0] Divisor;
  logic [W-1:0] Quotient;
  logic [W-1:0] Remainder;
  logic         Busy;
  logic         Ready;
  logic         DivZero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  always #5 clk = ~clk;

  divider_seq #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Run       (Run),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Ready     (Ready),
    .DivZero   (DivZero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 0;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = W;
    end
    return e;
  endfunction

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b);
    Run      = 1'b1;
    Dividend = a;
    Divisor  = b;
    sb.push_back(ref_model(a, b));
  endtask

  // Called just after the accepting edge; counts edges until Ready.
  task automatic wait_result(input bit disturb);
    int   lat;
    bit   both;
    bit   busy_seen;
    exp_t e;
    lat       = 0;
    both      = 1'b0;
    busy_seen = 1'b0;
    Run       = 1'b0;
    while (!Ready && lat <= 100) begin
      if (Busy && Ready) both = 1'b1;
      busy_seen |= Busy;
      if (disturb) begin
        Run      = 1'($urandom_range(0, 1));
        Dividend = $urandom;
        Divisor  = $urandom;
      end
      tick();
      lat++;
    end
    Run = 1'b0;
    if (Busy && Ready) both = 1'b1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    last_exp = e;
    check("latency", W'(lat), W'(e.lat));
    check("busy_ready_excl", W'(both), '0);
    check("busy_seen", W'(busy_seen), W'(e.lat != 0));
    check("quotient", Quotient, e.q);
    check("remainder", Remainder, e.r);
    check("divzero", W'(DivZero), W'(e.dz));
  endtask

  // Result must stay put in DONE while Run is low.
  task automatic check_hold(input int n);
    Run = 1'b0;
    repeat (n) tick();
    check("hold_ready", W'(Ready), W'(1));
    check("hold_quotient", Quotient, last_exp.q);
    check("hold_remainder", Remainder, last_exp.r);
    check("hold_divzero", W'(DivZero), W'(last_exp.dz));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           mode;

    Reset    = 1'b1;
    Run      = 1'b1;
    Dividend = 32'd100;
    Divisor  = 32'd7;
    repeat (3) tick();
    check("reset_quotient", Quotient, '0);
    check("reset_remainder", Remainder, '0);
    check("reset_busy", W'(Busy), '0);
    check("reset_ready", W'(Ready), '0);
    check("reset_divzero", W'(DivZero), '0);

    // First edge with Reset low and Run high accepts.
    Reset = 1'b0;
    sb.push_back(ref_model(32'd100, 32'd7));
    tick();
    check("first_accept_busy", W'(Busy), W'(1));
    wait_result(1'b0);
    check_hold(3);

    drive_op(32'd100, 32'd7);
    tick();
    wait_result(1'b0);

    drive_op(32'hFFFF_FFFF, 32'd1);
    tick();
    wait_result(1'b0);

    drive_op(32'hFFFF_FFFF, 32'h8000_0000);
    tick();
    wait_result(1'b0);

    drive_op(32'd5, 32'd0);
    tick();
    wait_result(1'b0);
    check_hold(2);

    // Back-to-back: Run on the first DONE edge goes straight to ITER.
    drive_op(32'd3, 32'd10);
    tick();
    wait_result(1'b0);
    drive_op(32'd50, 32'd5);
    tick();
    check("b2b_busy", W'(Busy), W'(1));
    wait_result(1'b0);

    // Reset in the middle of iterating.
    Run      = 1'b1;
    Dividend = 32'd1000;
    Divisor  = 32'd3;
    tick();
    Run = 1'b0;
    repeat (10) tick();
    Reset = 1'b1;
    #1;
    check("midreset_quotient", Quotient, '0);
    check("midreset_remainder", Remainder, '0);
    check("midreset_busy", W'(Busy), '0);
    check("midreset_ready", W'(Ready), '0);
    check("midreset_divzero", W'(DivZero), '0);
    tick();
    Reset = 1'b0;
    tick();
    drive_op(32'd100, 32'd7);
    tick();
    wait_result(1'b0);

    // Run and operands disturbed while iterating.
    drive_op(32'd123_456_789, 32'd1234);
    tick();
    wait_result(1'b1);

    for (int i = 0; i < 1000; i++) begin
      a    = $urandom;
      mode = $urandom_range(0, 19);
      if (mode == 0)      b = '0;
      else if (mode < 6)  b = W'($urandom_range(1, 255));
      else if (mode < 10) b = (a >> $urandom_range(0, 31)) | 32'd1;
      else                b = $urandom | 32'd1;
      if (mode == 19) a = W'($urandom_range(0, 15));
      drive_op(a, b);
      tick();
      wait_result(i % 50 == 0);
    end

    check("scoreboard_drained", W'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
